vis_accumulate: RTL and testbench
=================================

Name: vis_accumulate

Overview:
- Sits directly downstream of the correlator. It consumes the per-time-slice partial visibilities (real/imag) that the correlator emits once per frame.
- Sums each slot over NSUMS consecutive frames into ACCUM-bit signed totals, held in double-buffered RAM.
- Drains each completed integration as a ready/valid stream, TRATE words per integration, to the visibility readout/bus stage.

Parameters:
WIDTH, 4, input partial-sum width (matches correlator adder width); signed two's complement
TRATE, 30, slots (time-multiplexed correlations) per frame; must be >= 3
NSUMS, 16, frames per integration; must be >= 1
ACCUM, 24, accumulator width; must be >= WIDTH + clog2(NSUMS) + 1

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
valid_i  in  1  partial-sum word present this cycle
frame_i  in  1  qualifies valid_i: word is slot 0 of a new frame
re_i  in  WIDTH  signed real partial sum
im_i  in  WIDTH  signed imaginary partial sum
valid_o  out  1  output word valid
ready_i  in  1  downstream accepts word when valid_o & ready_i
last_o  out  1  word is slot TRATE-1 of the integration
re_o  out  ACCUM  signed real total
im_o  out  ACCUM  signed imaginary total
overrun_o  out  1  sticky: an integration completed while the previous one was still draining
misalign_o  out  1  sticky: frame_i seen at slot != 0, or frame ended without frame_i

Behaviour:
- Reset (async, active-low) clears the following:
  - outputs: valid_o, last_o, re_o, im_o, overrun_o, misalign_o = 0
  - state: slot counter, frame counter, bank select, drain state, synced flag = 0
  - RAM contents are not reset.
- Sync:
  - After reset, valid_i is ignored until the first valid_i & frame_i; that word becomes slot 0, frame 0.
- Slot counter:
  - Increments on each accepted valid_i and wraps TRATE-1 -> 0.
  - valid_i & frame_i when the slot counter != 0: set misalign_o, force slot 0, restart the frame counter at 0. The partial integration is discarded by overwriting.
  - Slot 0 arriving without frame_i: set misalign_o, accept the word as slot 0.
- Accumulate, write bank W = ~bank_sel, as a 2-stage read-modify-write:
  - Cycle 0: registered RAM read of slot.
  - Cycle 1: sum = (frame==0 ? 0 : ram) + sign-extended input, written back.
  - No forwarding. Same-slot accesses are >= TRATE >= 3 cycles apart.
  - Adds wrap modulo 2^ACCUM; the parameter rule guarantees no overflow.
- Integration complete (the write of slot TRATE-1 in frame NSUMS-1):
  - If the drainer is idle: toggle bank_sel on the cycle after that write commits, start a drain of the new read bank, reset the frame counter.
  - If the drainer is busy: set overrun_o, do not swap. The new integration is lost, the current drain continues, and the next integration reuses W.
- Drain FSM, states IDLE -> FETCH -> SEND:
  - FETCH issues a read of slot k. Data is registered into re_o/im_o and valid_o is asserted no more than 2 cycles after the swap.
  - valid_o, re_o, im_o and last_o hold stable while valid_o & !ready_i.
  - Prefetch allows 1 word/cycle throughput while ready_i is held high (skid of depth 1).
  - After the slot TRATE-1 handshake (last_o=1), return to IDLE and deassert valid_o on the next cycle unless a new drain starts.
- Input has no backpressure. Accumulation continues uninterrupted during a drain.
- Simultaneous completion and final-word handshake: the handshake finishes the drain first, so the swap proceeds with no overrun.
- Reset mid-operation: the drain is aborted and valid_o drops asynchronously; resync is required.

Decomposition:
- Package vis_pkg: slot/frame index widths (clog2 TRATE, clog2 NSUMS), drain FSM state enum, ACCUM width check function.
- Sub-module vis_bank_ram: simple dual-port RAM, 2*TRATE words of 2*ACCUM bits, registered read. Address = {bank, slot}. Port A serves read/write for accumulate; port B is read-only for drain.

Test Plan:
- TRATE=4, NSUMS=2, ACCUM=8; two frames with re=+1, im=-1 on every slot, ready_i=1 -> four words re=2, im=-2, last_o on the 4th only, overrun_o=0.
- NSUMS=4; re=-8, im=+7 every frame -> re_o=-32, im_o=+28 on all slots, sign-correct.
- Drain with ready_i low for 10 cycles after the first valid_o -> outputs held stable, all 4 words delivered once, in slot order 0..3.
- ready_i held low through completion of the next integration -> overrun_o=1; the drained data equals the first integration's totals.
- frame_i asserted at slot 2 -> misalign_o=1; the next full integration after restart produces correct totals.
- Reset asserted mid-drain -> valid_o=0 immediately; valid_i without frame_i is ignored; after frame_i, a normal integration completes.

Source files
------------

// File: rtl/vis_pkg.sv
// Shared types and elaboration helpers for the visibility accumulator.
//   drain_state_t : drain FSM encoding (IDLE -> FETCH -> SEND)
//   idx_width()   : index width for a count of n items (slot / frame counters)
//   accum_ok()    : true when ACCUM holds NSUMS worst-case partial sums without overflow
package vis_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2
   } drain_state_t;

   // Index width for n items; never less than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Accumulator must hold WIDTH-bit signed values summed NSUMS times.
   function automatic bit accum_ok(input int unsigned width,
                                   input int unsigned nsums,
                                   input int unsigned accum);
      return accum >= (width + $clog2(nsums) + 1);
   endfunction

endpackage

// File: rtl/vis_bank_ram.sv
// Double-buffered visibility RAM: one write port and two registered read ports.
//   clock            : rising-edge clock
//   we_a/waddr_a/wdata_a : accumulate write-back
//   raddr_a/rdata_a  : accumulate read (data one cycle after address)
//   raddr_b/rdata_b  : drain read (data one cycle after address)
// Address is {bank, slot}; depth is padded to a power of two so every address decodes.
// Contents are not reset.
module vis_bank_ram #(
   parameter int unsigned DW = 48,
   parameter int unsigned AW = 6
) (
   input  logic          clock,
   input  logic          we_a,
   input  logic [AW-1:0] waddr_a,
   input  logic [DW-1:0] wdata_a,
   input  logic [AW-1:0] raddr_a,
   output logic [DW-1:0] rdata_a,
   input  logic [AW-1:0] raddr_b,
   output logic [DW-1:0] rdata_b
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];

   // Write-back plus two independent registered reads.
   always_ff @(posedge clock) begin
      if (we_a) mem[waddr_a] <= wdata_a;
      rdata_a <= mem[raddr_a];
      rdata_b <= mem[raddr_b];
   end

endmodule

// File: rtl/vis_accumulate.sv
// Integrates correlator partial visibilities over NSUMS frames and drains each
// completed integration as a ready/valid stream of TRATE words.
//   clock, reset        : rising-edge clock, async active-low reset
//   valid_i, frame_i    : input word strobe; frame_i marks slot 0 of a frame
//   re_i, im_i          : signed WIDTH-bit partial sums
//   valid_o, ready_i    : output handshake
//   last_o              : output word is slot TRATE-1
//   re_o, im_o          : signed ACCUM-bit totals
//   overrun_o           : sticky, integration completed while draining
//   misalign_o          : sticky, frame marker out of place
module vis_accumulate
   import vis_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned TRATE = 30,
   parameter int unsigned NSUMS = 16,
   parameter int unsigned ACCUM = 24
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             valid_i,
   input  logic             frame_i,
   input  logic [WIDTH-1:0] re_i,
   input  logic [WIDTH-1:0] im_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             last_o,
   output logic [ACCUM-1:0] re_o,
   output logic [ACCUM-1:0] im_o,
   output logic             overrun_o,
   output logic             misalign_o
);

   localparam int unsigned SW = idx_width(TRATE);
   localparam int unsigned FW = idx_width(NSUMS);
   localparam int unsigned AW = SW + 1;
   localparam int unsigned DW = 2 * ACCUM;
   localparam logic [SW-1:0] SLOT_LAST  = SW'(TRATE - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(NSUMS - 1);

   if (!accum_ok(WIDTH, NSUMS, ACCUM) || TRATE < 3 || NSUMS < 1) begin : g_param_err
      $error("vis_accumulate: illegal parameter set");
   end

   // ---------------- input sync / slot tracking ----------------
   logic          synced;
   logic [SW-1:0] slot_cnt, slot_use;
   logic [FW-1:0] frame_cnt, frame_use;
   logic          bank_sel;
   logic          accept, misalign_evt, done0;

   // A frame marker always forces slot 0; out of place it also restarts the integration.
   always_comb begin
      slot_use  = slot_cnt;
      frame_use = frame_cnt;
      if (frame_i) begin
         slot_use = '0;
         if (slot_cnt != '0) frame_use = '0;
      end
   end

   assign accept       = valid_i & (synced | frame_i);
   assign misalign_evt = accept & synced & (frame_i ? (slot_cnt != '0) : (slot_cnt == '0));
   assign done0        = (slot_use == SLOT_LAST) && (frame_use == FRAME_LAST);

   // Stage-1 (write-back) pipeline registers.
   logic             p1_valid, p1_first, p1_done;
   logic [SW-1:0]    p1_slot;
   logic [ACCUM-1:0] p1_re, p1_im;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         synced     <= 1'b0;
         slot_cnt   <= '0;
         frame_cnt  <= '0;
         misalign_o <= 1'b0;
         p1_valid   <= 1'b0;
         p1_first   <= 1'b0;
         p1_done    <= 1'b0;
         p1_slot    <= '0;
         p1_re      <= '0;
         p1_im      <= '0;
      end else begin
         p1_valid <= accept;
         if (accept) begin
            synced    <= 1'b1;
            slot_cnt  <= (slot_use == SLOT_LAST) ? '0 : slot_use + SW'(1);
            if (slot_use == SLOT_LAST)
               frame_cnt <= (frame_use == FRAME_LAST) ? '0 : frame_use + FW'(1);
            else
               frame_cnt <= frame_use;
            p1_slot   <= slot_use;
            p1_first  <= (frame_use == '0);
            p1_done   <= done0;
            p1_re     <= {{(ACCUM-WIDTH){re_i[WIDTH-1]}}, re_i};
            p1_im     <= {{(ACCUM-WIDTH){im_i[WIDTH-1]}}, im_i};
         end
         if (misalign_evt) misalign_o <= 1'b1;
      end
   end

   // ---------------- RAM and read-modify-write ----------------
   logic [DW-1:0]    ram_a_q, ram_b_q, wdata;
   logic [ACCUM-1:0] base_re, base_im;
   logic [SW-1:0]    rd_slot;

   // Frame 0 overwrites, later frames add to the stored total.
   assign base_re = p1_first ? '0 : ram_a_q[DW-1:ACCUM];
   assign base_im = p1_first ? '0 : ram_a_q[ACCUM-1:0];
   assign wdata   = {base_re + p1_re, base_im + p1_im};

   vis_bank_ram #(.DW(DW), .AW(AW)) u_ram (
      .clock   (clock),
      .we_a    (p1_valid),
      .waddr_a ({~bank_sel, p1_slot}),
      .wdata_a (wdata),
      .raddr_a ({~bank_sel, slot_use}),
      .rdata_a (ram_a_q),
      .raddr_b ({bank_sel, rd_slot}),
      .rdata_b (ram_b_q)
   );

   // ---------------- drain control ----------------
   drain_state_t state, state_next;
   logic         pop, drain_free, complete, start, issue, room;
   logic         pend, pend_last, skid_v, skid_last;
   logic [ACCUM-1:0] skid_re, skid_im;
   logic [1:0]   occ;

   assign pop        = valid_o & ready_i;
   assign complete   = p1_valid & p1_done;
   // A final-word handshake in the same cycle frees the drainer for the new bank.
   assign drain_free = (state == IDLE) || ((state == SEND) && pop && last_o);
   assign start      = complete & drain_free;
   // Words held after this cycle (output + skid + in-flight read) must leave room for one more.
   assign occ        = 2'(valid_o) + 2'(skid_v) + 2'(pend);
   assign room       = (occ - 2'(pop)) <= 2'd1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      issue      = 1'b0;
      case (state)
         IDLE:  if (start) state_next = FETCH;
         FETCH: if (room) begin
                   issue = 1'b1;
                   if (rd_slot == SLOT_LAST) state_next = SEND;
                end
         SEND:  if (pop && last_o) state_next = start ? FETCH : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Bank swap, sticky overrun and drain read pointer.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bank_sel  <= 1'b0;
         overrun_o <= 1'b0;
         rd_slot   <= '0;
         pend      <= 1'b0;
         pend_last <= 1'b0;
      end else begin
         bank_sel  <= bank_sel ^ start;
         if (complete && !drain_free) overrun_o <= 1'b1;
         if (start)      rd_slot <= '0;
         else if (issue) rd_slot <= rd_slot + SW'(1);
         pend      <= issue;
         pend_last <= issue && (rd_slot == SLOT_LAST);
      end
   end

   // Output register with one-deep skid; read data lands in whichever is free.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_o   <= 1'b0;
         last_o    <= 1'b0;
         re_o      <= '0;
         im_o      <= '0;
         skid_v    <= 1'b0;
         skid_last <= 1'b0;
         skid_re   <= '0;
         skid_im   <= '0;
      end else if (!valid_o || ready_i) begin
         if (skid_v) begin
            valid_o   <= 1'b1;
            last_o    <= skid_last;
            re_o      <= skid_re;
            im_o      <= skid_im;
            skid_v    <= pend;
            skid_last <= pend_last;
            skid_re   <= ram_b_q[DW-1:ACCUM];
            skid_im   <= ram_b_q[ACCUM-1:0];
         end else if (pend) begin
            valid_o <= 1'b1;
            last_o  <= pend_last;
            re_o    <= ram_b_q[DW-1:ACCUM];
            im_o    <= ram_b_q[ACCUM-1:0];
         end else begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
         end
      end else if (pend) begin
         skid_v    <= 1'b1;
         skid_last <= pend_last;
         skid_re   <= ram_b_q[DW-1:ACCUM];
         skid_im   <= ram_b_q[ACCUM-1:0];
      end
   end

endmodule

// File: tb/tb_vis_accumulate.sv
// Scoreboard bench for vis_accumulate (TRATE=4, ACCUM=8; NSUMS=2 main DUT, NSUMS=4 sign DUT).
module tb_vis_accumulate;

   logic       clock, reset;
   logic       valid_i, frame_i, ready_i;
   logic [3:0] re_i, im_i;
   logic       valid_o, last_o, overrun_o, misalign_o;
   logic [7:0] re_o, im_o;

   logic       valid4_i, frame4_i, ready4_i;
   logic [3:0] re4_i, im4_i;
   logic       valid4_o, last4_o, overrun4_o, misalign4_o;
   logic [7:0] re4_o, im4_o;

   typedef struct packed {
      logic [7:0] re;
      logic [7:0] im;
      logic       last;
   } exp_t;

   exp_t sb[$];
   exp_t sb4[$];
   int   checks = 0;
   int   errors = 0;

   vis_accumulate #(.WIDTH(4), .TRATE(4), .NSUMS(2), .ACCUM(8)) u_dut (
      .clock(clock), .reset(reset), .valid_i(valid_i), .frame_i(frame_i),
      .re_i(re_i), .im_i(im_i), .valid_o(valid_o), .ready_i(ready_i),
      .last_o(last_o), .re_o(re_o), .im_o(im_o),
      .overrun_o(overrun_o), .misalign_o(misalign_o)
   );

   vis_accumulate #(.WIDTH(4), .TRATE(4), .NSUMS(4), .ACCUM(8)) u_dut4 (
      .clock(clock), .reset(reset), .valid_i(valid4_i), .frame_i(frame4_i),
      .re_i(re4_i), .im_i(im4_i), .valid_o(valid4_o), .ready_i(ready4_i),
      .last_o(last4_o), .re_o(re4_o), .im_o(im4_o),
      .overrun_o(overrun4_o), .misalign_o(misalign4_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input bit sel4, input bit f, input int r, input int i);
      if (sel4) begin
         valid4_i = 1'b1; frame4_i = f; re4_i = 4'(r); im4_i = 4'(i);
      end else begin
         valid_i = 1'b1; frame_i = f; re_i = 4'(r); im_i = 4'(i);
      end
      tick();
      valid_i = 1'b0; frame_i = 1'b0; valid4_i = 1'b0; frame4_i = 1'b0;
   endtask

   // Two frames of slot values r = rb + rs*slot, i = ib + is*slot on the main DUT.
   task automatic send_integ(input int rb, input int rs, input int ib, input int is);
      for (int f = 0; f < 2; f++)
         for (int s = 0; s < 4; s++)
            drive(1'b0, s == 0, rb + rs * s, ib + is * s);
   endtask

   task automatic push_integ(input int rb, input int rs, input int ib, input int is);
      exp_t e;
      for (int s = 0; s < 4; s++) begin
         e.re   = 8'(2 * (rb + rs * s));
         e.im   = 8'(2 * (ib + is * s));
         e.last = (s == 3);
         sb.push_back(e);
      end
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!valid_o && n < 100) begin tick(); n++; end
      check(name, int'(valid_o), 1);
   endtask

   task automatic wait_empty(input string name);
      int n = 0;
      while ((sb.size() != 0 || valid_o) && n < 300) begin tick(); n++; end
      check(name, (n >= 300) ? sb.size() + 1 : 0, 0);
   endtask

   // Monitor: output stability under backpressure and in-order scoreboard compare.
   logic       hold;
   logic [7:0] p_re, p_im;
   logic       p_last;
   exp_t       me;

   always @(negedge clock) begin
      if (!reset) begin
         hold = 1'b0;
      end else begin
         if (hold) begin
            checks++;
            if (!valid_o || re_o !== p_re || im_o !== p_im || last_o !== p_last) begin
               errors++;
               $display("FAIL hold_stable: got v=%0b re=%0d im=%0d last=%0b, expected v=1 re=%0d im=%0d last=%0b",
                        valid_o, $signed(re_o), $signed(im_o), last_o, $signed(p_re), $signed(p_im), p_last);
            end
         end
         if (valid_o && ready_i) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_word: got re=%0d im=%0d, expected no word", $signed(re_o), $signed(im_o));
            end else begin
               me = sb.pop_front();
               if (re_o !== me.re || im_o !== me.im || last_o !== me.last) begin
                  errors++;
                  $display("FAIL drain_word: got re=%0d im=%0d last=%0b, expected re=%0d im=%0d last=%0b",
                           $signed(re_o), $signed(im_o), last_o, $signed(me.re), $signed(me.im), me.last);
               end
            end
         end
         hold   = valid_o && !ready_i;
         p_re   = re_o;
         p_im   = im_o;
         p_last = last_o;
      end
   end

   exp_t me4;
   always @(negedge clock) begin
      if (reset && valid4_o && ready4_i) begin
         checks++;
         if (sb4.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word4: got re=%0d im=%0d, expected no word", $signed(re4_o), $signed(im4_o));
         end else begin
            me4 = sb4.pop_front();
            if (re4_o !== me4.re || im4_o !== me4.im || last4_o !== me4.last) begin
               errors++;
               $display("FAIL sign_word: got re=%0d im=%0d last=%0b, expected re=%0d im=%0d last=%0b",
                        $signed(re4_o), $signed(im4_o), last4_o, $signed(me4.re), $signed(me4.im), me4.last);
            end
         end
      end
   end

   initial begin
      exp_t e;
      int   n;
      reset = 1'b0; ready_i = 1'b1; ready4_i = 1'b1;
      valid_i = 1'b0; frame_i = 1'b0; re_i = '0; im_i = '0;
      valid4_i = 1'b0; frame4_i = 1'b0; re4_i = '0; im4_i = '0;
      repeat (3) tick();
      reset = 1'b1;
      tick();

      // Reset state
      check("rst_valid",    int'(valid_o), 0);
      check("rst_last",     int'(last_o), 0);
      check("rst_re",       int'(re_o), 0);
      check("rst_im",       int'(im_o), 0);
      check("rst_overrun",  int'(overrun_o), 0);
      check("rst_misalign", int'(misalign_o), 0);

      // Basic integration: +1/-1 over two frames -> 2/-2
      push_integ(1, 0, -1, 0);
      send_integ(1, 0, -1, 0);
      wait_empty("basic_drain_done");
      check("basic_overrun", int'(overrun_o), 0);

      // Sign check on NSUMS=4 DUT: -8/+7 x4 -> -32/+28
      for (int s = 0; s < 4; s++) begin
         e.re = 8'(-32); e.im = 8'(28); e.last = (s == 3);
         sb4.push_back(e);
      end
      for (int f = 0; f < 4; f++)
         for (int s = 0; s < 4; s++)
            drive(1'b1, s == 0, -8, 7);
      n = 0;
      while ((sb4.size() != 0 || valid4_o) && n < 300) begin tick(); n++; end
      check("sign_drain_done", (n >= 300) ? 1 : 0, 0);
      check("sign_misalign", int'(misalign4_o), 0);

      // Backpressure: ready low for 10 cycles after first valid_o, distinct per-slot values
      ready_i = 1'b0;
      push_integ(1, 1, -3, 2);
      send_integ(1, 1, -3, 2);
      wait_valid("stall_valid");
      repeat (10) tick();
      ready_i = 1'b1;
      wait_empty("stall_drain_done");
      check("stall_overrun", int'(overrun_o), 0);

      // Overrun: next integration completes while the first is still stuck
      ready_i = 1'b0;
      push_integ(2, -1, 3, 1);
      send_integ(2, -1, 3, 1);
      wait_valid("ovr_valid");
      send_integ(-4, 0, -4, 0);
      repeat (3) tick();
      check("ovr_set", int'(overrun_o), 1);
      ready_i = 1'b1;
      wait_empty("ovr_drain_done");
      check("ovr_sticky", int'(overrun_o), 1);

      // Misalign: frame marker at slot 2, then a clean restart integration
      check("mis_before", int'(misalign_o), 0);
      drive(1'b0, 1'b1, 7, 7);
      drive(1'b0, 1'b0, 7, 7);
      push_integ(-2, 1, 5, -3);
      send_integ(-2, 1, 5, -3);
      wait_empty("mis_drain_done");
      check("mis_set", int'(misalign_o), 1);

      // Reset mid-drain
      ready_i = 1'b0;
      push_integ(3, 0, 3, 0);
      send_integ(3, 0, 3, 0);
      wait_valid("rstd_valid");
      reset = 1'b0;
      #1;
      check("rstd_valid_drop", int'(valid_o), 0);
      sb.delete();
      repeat (2) tick();
      reset = 1'b1;
      tick();
      check("rstd_overrun_clr", int'(overrun_o), 0);
      check("rstd_misalign_clr", int'(misalign_o), 0);
      for (int k = 0; k < 6; k++) drive(1'b0, 1'b0, 5, -5);
      ready_i = 1'b1;
      repeat (4) tick();
      check("rstd_unsynced_idle", int'(valid_o), 0);
      push_integ(-1, 2, 4, -1);
      send_integ(-1, 2, 4, -1);
      wait_empty("rstd_drain_done");
      check("rstd_misalign", int'(misalign_o), 0);
      check("rstd_overrun", int'(overrun_o), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
